// File: rtl/pipeline_hazard_controller_if.sv
// Issue handshake between decode and the hazard controller.
// Valid/ready: decode holds issue_valid and the operand/destination fields
// stable while it waits. An instruction is transferred on a rising clock
// edge only when issue_valid && issue_ready are both high in that cycle.
// issue_ready may drop combinationally (load-use, flush, reset), and decode
// must not assume acceptance without it.
interface pipeline_hazard_controller_if #(
  parameter int ADDR_W = 5
);
  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] issue_rs;
  logic [ADDR_W-1:0] issue_rt;
  logic              issue_uses_rt;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_writes;
  logic              issue_is_load;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_uses_rt,
           issue_rd, issue_writes, issue_is_load,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_uses_rt,
           issue_rd, issue_writes, issue_is_load,
    output issue_ready
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the EX/MEM/WB datapath: tracks in-flight
// destination tags, produces registered operand forward selects, stalls
// issue for one cycle on load-use, drives write-back and counts stalls.
module pipeline_hazard_controller #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  pipeline_hazard_controller_if.slave issue,
  input  logic                       flush,
  output logic                       ex_valid,
  output logic [1:0]                 fwd_sel_a,
  output logic [1:0]                 fwd_sel_b,
  output logic                       mem_valid,
  output logic                       wb_en,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // EX and MEM stage tags; WB is represented by wb_en/wb_addr themselves.
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_writes;
  logic              ex_is_load;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_writes;

  logic       load_use;
  logic       accept;
  logic       ex_fwd_ok;
  logic       mem_fwd_ok;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Hazard detection, handshake and forward-select selection for the
  // instruction currently offered by decode.
  always_comb begin
    load_use = ex_valid && ex_is_load && ex_writes && (ex_rd != '0) &&
               ((ex_rd == issue.issue_rs) ||
                (issue.issue_uses_rt && (ex_rd == issue.issue_rt)));
    issue.issue_ready = !reset && !flush && !load_use;
    accept = issue.issue_valid && issue.issue_ready;

    // A load in EX can never be a forward source; that case is the stall.
    ex_fwd_ok  = ex_valid && ex_writes && (ex_rd != '0) && !ex_is_load;
    mem_fwd_ok = mem_valid && mem_writes && (mem_rd != '0);

    sel_a = SEL_RF;
    if (issue.issue_rs != '0) begin
      if (ex_fwd_ok && (ex_rd == issue.issue_rs))
        sel_a = SEL_EX;
      else if (mem_fwd_ok && (mem_rd == issue.issue_rs))
        sel_a = SEL_MEM;
    end

    sel_b = SEL_RF;
    if (issue.issue_uses_rt && (issue.issue_rt != '0)) begin
      if (ex_fwd_ok && (ex_rd == issue.issue_rt))
        sel_b = SEL_EX;
      else if (mem_fwd_ok && (mem_rd == issue.issue_rt))
        sel_b = SEL_MEM;
    end
  end

  // Pipeline advance: EX loads the accepted instruction or a bubble, MEM
  // follows EX unless flushed, and the MEM instruction always retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_writes  <= 1'b0;
      ex_is_load <= 1'b0;
      fwd_sel_a  <= SEL_RF;
      fwd_sel_b  <= SEL_RF;
      mem_valid  <= 1'b0;
      mem_rd     <= '0;
      mem_writes <= 1'b0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
    end else begin
      ex_valid   <= accept;
      ex_rd      <= accept ? issue.issue_rd : '0;
      ex_writes  <= accept && issue.issue_writes;
      ex_is_load <= accept && issue.issue_is_load;
      fwd_sel_a  <= accept ? sel_a : SEL_RF;
      fwd_sel_b  <= accept ? sel_b : SEL_RF;

      mem_valid  <= ex_valid && !flush;
      mem_rd     <= ex_rd;
      mem_writes <= ex_writes;

      wb_en <= mem_valid && mem_writes && (mem_rd != '0);
      if (mem_valid && mem_writes && (mem_rd != '0))
        wb_addr <= mem_rd;
    end
  end

  // Saturating count of cycles in which decode was held off by load-use.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (issue.issue_valid && load_use && !flush && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              ex_valid;
  logic              mem_valid;
  logic              wb_en;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic [ADDR_W-1:0] wb_addr;
  logic [CNT_W-1:0]  stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_controller_if #(.ADDR_W(ADDR_W)) bus ();

  pipeline_hazard_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue        (bus),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .mem_valid    (mem_valid),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .stall_cycles (stall_cycles)
  );

  // Clock
  always #5 clk = ~clk;

  // Time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd, input logic wr,
                       input logic ld);
    bus.issue_valid   = v;
    bus.issue_rs      = rs;
    bus.issue_rt      = rt;
    bus.issue_uses_rt = urt;
    bus.issue_rd      = rd;
    bus.issue_writes  = wr;
    bus.issue_is_load = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    idle();
    step();
    step();
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0d expected 0", bus.issue_ready); end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %0d expected 0", ex_valid); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %0d expected 0", mem_valid); end
    n_checks++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b); end
    n_checks++; if (wb_en !== 1'b0 || wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wb: got en %0d addr %0d expected 0/0", wb_en, wb_addr); end
    n_checks++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %0d expected 1", bus.issue_ready); end
  endtask

  task automatic test_no_dep();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL nodep_ex_valid: got %0d expected 1", ex_valid); end
    n_checks++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL nodep_fwd_r3: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b); end
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    step();
    n_checks++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL nodep_fwd_r4: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b); end
    n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL nodep_wb_early: got %0d expected 0", wb_en); end
    idle();
    step();
    n_checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd3) begin n_fail++; $display("FAIL nodep_wb_r3: got en %0d addr %0d expected 1/3", wb_en, wb_addr); end
    step();
    n_checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd4) begin n_fail++; $display("FAIL nodep_wb_r4: got en %0d addr %0d expected 1/4", wb_en, wb_addr); end
    step();
    n_checks++; if (wb_en !== 1'b0 || wb_addr !== 5'd4) begin n_fail++; $display("FAIL nodep_wb_hold: got en %0d addr %0d expected 0/4", wb_en, wb_addr); end
    drain();
  endtask

  task automatic test_fwd_ex();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    step();
    n_checks++; if (fwd_sel_a !== 2'b01) begin n_fail++; $display("FAIL ex_fwd_a: got %0d expected 1", fwd_sel_a); end
    n_checks++; if (fwd_sel_b !== 2'b01) begin n_fail++; $display("FAIL ex_fwd_b: got %0d expected 1", fwd_sel_b); end
    drain();
  endtask

  task automatic test_fwd_mem();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd10, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0);
    step();
    n_checks++; if (fwd_sel_a !== 2'b10) begin n_fail++; $display("FAIL mem_fwd_a: got %0d expected 2", fwd_sel_a); end
    n_checks++; if (fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL mem_fwd_b: got %0d expected 0", fwd_sel_b); end
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd12, 5'd13, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd14, 1'b1, 1'b0);
    step();
    n_checks++; if (fwd_sel_a !== 2'b01) begin n_fail++; $display("FAIL youngest_wins_a: got %0d expected 1", fwd_sel_a); end
    n_checks++; if (fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL imm_b_no_fwd: got %0d expected 0", fwd_sel_b); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready_low: got %0d expected 0", bus.issue_ready); end
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %0d expected 0", ex_valid); end
    n_checks++; if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall_count: got %0d expected 1", stall_cycles); end
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready_back: got %0d expected 1", bus.issue_ready); end
    step();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_consumer_ex: got %0d expected 1", ex_valid); end
    n_checks++; if (fwd_sel_b !== 2'b10 || fwd_sel_a !== 2'b00) begin n_fail++; $display("FAIL lu_fwd: got a %0d b %0d expected 0/2", fwd_sel_a, fwd_sel_b); end
    n_checks++; if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall_once: got %0d expected 1", stall_cycles); end
    drain();
  endtask

  task automatic test_reg_zero();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd15, 1'b0, 1'b0);
    step();
    n_checks++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL r0_fwd: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b); end
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL r0_no_wb: got %0d expected 0 at step %0d", wb_en, i); end
    end
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd15, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL r0_load_no_stall: got %0d expected 1", bus.issue_ready); end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
    step();
    n_checks++; if (ex_valid !== 1'b1 || mem_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got ex %0d mem %0d expected 1/1", ex_valid, mem_valid); end
    drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0d expected 0", bus.issue_ready); end
    step();
    flush = 1'b0;
    idle();
    n_checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got ex %0d mem %0d expected 0/0", ex_valid, mem_valid); end
    n_checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd10) begin n_fail++; $display("FAIL flush_mem_retires: got en %0d addr %0d expected 1/10", wb_en, wb_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL flush_no_wb: got %0d expected 0 at step %0d", wb_en, i); end
    end
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    n_checks++; if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL flush_over_hazard: got %0d expected 1", stall_cycles); end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %0d expected 0", ex_valid); end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd7, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_load: got %0d expected 1", bus.issue_ready); end
    step();
    drive(1'b1, 5'd7, 5'd2, 1'b1, 5'd16, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %0d expected 0", bus.issue_ready); end
    step();
    n_checks++; if (stall_cycles !== 16'd2 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_one_cycle: got stall %0d ready %0d expected 2/1", stall_cycles, bus.issue_ready); end
    step();
    n_checks++; if (fwd_sel_a !== 2'b10 || fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL b2b_fwd: got %0d/%0d expected 2/0", fwd_sel_a, fwd_sel_b); end
    drain();
  endtask

  task automatic test_saturate();
    force dut.stall_cycles = 16'hFFFF;
    #1;
    release dut.stall_cycles;
    step();
    n_checks++; if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preset: got %0h expected ffff", stall_cycles); end
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    step();
    n_checks++; if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h expected ffff", stall_cycles); end
    drain();
    n_checks++; if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_after: got %0h expected ffff", stall_cycles); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    idle();
    step();
    n_checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got ex %0d mem %0d expected 0/0", ex_valid, mem_valid); end
    n_checks++; if (wb_en !== 1'b0 || stall_cycles !== 16'd0) begin n_fail++; $display("FAIL midreset_wb_stall: got en %0d stall %0d expected 0/0", wb_en, stall_cycles); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL midreset_no_wb: got %0d expected 0 at step %0d", wb_en, i); end
    end
  endtask

  // Scenario sequence and final report
  initial begin
    test_reset();
    test_no_dep();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_reg_zero();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequencing and hazard controller for the 32-bit pipelined datapath (register file read, ALU, two result-register stages).
- Tracks destination-register tags of in-flight instructions across EX, MEM and WB.
- Generates registered forwarding selects for the ALU operand muxes and stalls issue on load-use hazards.
- Drives register-file write-back and counts stall cycles; sits beside the datapath, fed by decode.

Parameters:
- ADDR_W, 5, register address width (32 registers; register 0 hard-wired zero).
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- issue_valid  input  1  decode presents an instruction.
- issue_ready  output  1  controller accepts the instruction this cycle.
- issue_rs  input  ADDR_W  source A register.
- issue_rt  input  ADDR_W  source B register.
- issue_uses_rt  input  1  operand B comes from rt (0 = immediate/const_amt, never forwarded).
- issue_rd  input  ADDR_W  destination register.
- issue_writes  input  1  instruction writes rd.
- issue_is_load  input  1  rd value is available only at end of MEM.
- flush  input  1  kill younger in-flight instructions.
- ex_valid  output  1  EX stage holds a real instruction (not a bubble).
- fwd_sel_a  output  2  operand A mux: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- fwd_sel_b  output  2  operand B mux, same encoding.
- mem_valid  output  1  MEM stage holds a real instruction.
- wb_en  output  1  register-file write enable.
- wb_addr  output  ADDR_W  register-file write address.
- stall_cycles  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: all stage valid bits 0, tags 0, fwd_sel_a/b = 00, wb_en 0, wb_addr 0, stall_cycles 0. issue_ready is 0 during the reset cycle.
- Per-stage state (EX, MEM, WB): valid, rd, writes, is_load. The pipeline advances every cycle; there is no back-pressure downstream of EX.
- Accept: issue_valid && issue_ready. The accepted instruction enters EX next cycle. Otherwise a bubble (valid = 0) enters EX.
- Load-use hazard (combinational, cycle t): EX.valid && EX.is_load && EX.writes && EX.rd != 0, and EX.rd matches issue_rs, or matches issue_rt with issue_uses_rt.
  - On a hazard, issue_ready = 0 and a bubble is inserted.
  - Otherwise issue_ready = !reset && !flush.
- Forward selects are registered at acceptance and are valid while the instruction is in EX (cycle t+1). Per operand, evaluated at cycle t, in priority order:
  1. 01 if EX.valid, EX.writes, EX.rd != 0, EX.rd == src, and not a load. The load case is excluded by the stall.
  2. 10 if MEM.valid, MEM.writes, MEM.rd != 0, MEM.rd == src.
  3. Otherwise 00.
  - The youngest producer always wins.
  - Source register 0 always selects 00.
  - Operand B is 00 when issue_uses_rt = 0.
  - On a bubble, fwd_sel_a/b are 00.
- Write-back: wb_en = WB.valid && WB.writes && WB.rd != 0, registered from stage state; wb_addr = WB.rd whenever wb_en, else holds its last value.
- stall_cycles increments by 1 on each cycle with issue_valid && load-use hazard. It saturates at all-ones and never wraps.
- Flush: on the edge where flush = 1, the EX and MEM valid bits become 0. The instruction in MEM still moves to WB and completes, because it is older than the flush point. The issue offered in the flush cycle is not accepted. Flush has priority over a simultaneous hazard: no stall is counted.
- Reset mid-operation: all in-flight instructions are discarded and no wb_en fires on the following cycle.
- Back-to-back loads into the same rd: each load-use is evaluated independently; the stall lasts at most 1 cycle per dependent instruction.

Test Plan:
- Reset, then issue add r3 and add r4 with no dependencies: fwd selects 00/00 for both; wb_en pulses with wb_addr 3, then 4, three cycles after each issue.
- Issue add r5 ← r1,r2, then sub r6 ← r5,r5: the second instruction's EX cycle shows fwd_sel_a = 01 and fwd_sel_b = 01.
- Issue r5 producer, an unrelated instruction, then a r5 consumer on rs: fwd_sel_a = 10. Insert an intervening r5 writer: fwd_sel_a = 01 (youngest wins).
- Issue load r7, then a consumer of r7 on rt: issue_ready is low for exactly 1 cycle, stall_cycles = 1, then fwd_sel_b = 10.
- Issue a writer to r0, then a reader of r0: fwd selects 00 and wb_en never asserts.
- Assert flush with valid instructions in EX and MEM: MEM instruction still produces wb_en; the EX one never does. Separately, force stall_cycles to all-ones and stall again: it holds at 0xFFFF.
